// File: rtl/oric_tap_recorder.sv
// Oric cassette capture: times edge-to-edge periods on K7_TAPEOUT, deframes fast-format
// bytes and hands each to the SDRAM arbiter over a one-outstanding toggle req/ack.
module oric_tap_recorder #(
  parameter int SHORT_MAX = 520,
  parameter int LONG_MAX  = 800,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              tape_in,
  input  logic              motor_on,
  input  logic              record,
  output logic [7:0]        byte_out,
  output logic [ADDR_W-1:0] byte_addr,
  output logic              byte_req,
  input  logic              byte_ack,
  output logic              running,
  output logic              full,
  output logic              overrun,
  output logic [7:0]        parity_errs,
  output logic [ADDR_W-1:0] last_addr
);
  localparam logic [11:0]       SHORT_L   = 12'(SHORT_MAX);
  localparam logic [11:0]       LONG_L    = 12'(LONG_MAX);
  localparam logic [ADDR_W-1:0] ADDR_STOP = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic        tape_p0, tape_p1, tape_p2;
  logic [11:0] period_cnt;
  logic        timed;
  logic [7:0]  shifter;
  logic [2:0]  bit_idx;
  logic [1:0]  stop_ones;
  logic        parity_acc;
  logic        rise, bit_one, bit_zero, gap, adv;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign rise = tape_p1 & ~tape_p2;
  assign adv  = running & ~full;

  // The counter value seen in the edge cycle is the period; the tick lost to the edge is not counted.
  always_comb begin
    bit_one  = 1'b0;
    bit_zero = 1'b0;
    gap      = 1'b0;
    if (rise && timed) begin
      if (period_cnt <= SHORT_L)     bit_one  = 1'b1;
      else if (period_cnt <= LONG_L) bit_zero = 1'b1;
      else                           gap      = 1'b1;
    end else if (!rise && ce && period_cnt == LONG_L && state != HUNT) begin
      gap = 1'b1;
    end
  end

  // Stage p0/p1: two-flop synchroniser; p2: previous level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tape_p0    <= 1'b0;
      tape_p1    <= 1'b0;
      tape_p2    <= 1'b0;
      period_cnt <= '0;
    end else begin
      tape_p0 <= tape_in;
      tape_p1 <= tape_p0;
      tape_p2 <= tape_p1;
      if (rise)    period_cnt <= '0;
      else if (ce) period_cnt <= sat_inc12(period_cnt);
    end
  end

  // Deframing FSM and handshake outputs, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      timed       <= 1'b0;
      shifter     <= '0;
      bit_idx     <= '0;
      stop_ones   <= '0;
      parity_acc  <= 1'b0;
      byte_out    <= '0;
      byte_addr   <= '0;
      byte_req    <= 1'b0;
      running     <= 1'b0;
      full        <= 1'b0;
      overrun     <= 1'b0;
      parity_errs <= '0;
      last_addr   <= '0;
    end else begin
      running <= record & motor_on & ~full;
      // A timeout gap leaves no usable reference edge, so the next edge only restarts timing.
      if (rise)     timed <= 1'b1;
      else if (gap) timed <= 1'b0;

      if (!adv || gap) begin
        state <= HUNT;
      end else if (bit_one || bit_zero) begin
        case (state)
          HUNT: begin
            if (bit_zero) begin
              state      <= DATA;
              bit_idx    <= '0;
              shifter    <= '0;
              parity_acc <= 1'b0;
            end
          end
          DATA: begin
            shifter    <= {bit_one, shifter[7:1]};
            parity_acc <= parity_acc ^ bit_one;
            bit_idx    <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            if (parity_acc == bit_one) parity_errs <= sat_inc8(parity_errs);
            if (byte_req == byte_ack) begin
              byte_out  <= shifter;
              byte_addr <= last_addr;
              byte_req  <= ~byte_req;
              last_addr <= last_addr + ADDR_W'(1);
              if (last_addr == ADDR_STOP) full <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            stop_ones <= '0;
            state     <= STOP;
          end
          STOP: begin
            if (bit_zero) begin
              state      <= DATA;
              bit_idx    <= '0;
              shifter    <= '0;
              parity_acc <= 1'b0;
            end else if (stop_ones == 2'd2) begin
              state <= HUNT;
            end else begin
              stop_ones <= stop_ones + 2'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oric_tap_recorder.sv
// Bench for oric_tap_recorder: frames are synthesised from period lists, expected
// (byte, address) pairs are queued by a frame-level model and popped on each req toggle.
module tb_oric_tap_recorder;
  logic        clk = 1'b0, reset = 1'b1, ce = 1'b1;
  logic        tape_in = 1'b0, motor_on = 1'b1, record = 1'b1, byte_ack = 1'b0;
  logic [7:0]  byte_out, parity_errs;
  logic [23:0] byte_addr, last_addr;
  logic        byte_req, running, full, overrun;

  logic        tape_s = 1'b0, ack_s = 1'b0;
  logic [7:0]  byte_out_s, parity_errs_s;
  logic [3:0]  byte_addr_s, last_addr_s;
  logic        byte_req_s, running_s, full_s, overrun_s;

  int checks = 0, failures = 0;

  typedef struct packed { logic [7:0] b; logic [23:0] a; } exp_t;
  exp_t q_m[$], q_s[$];
  int   m_addr = 0, s_addr = 0, m_perr = 0;
  bit   hold = 1'b0, outstanding = 1'b0, m_overrun = 1'b0, s_full = 1'b0;

  oric_tap_recorder u_dut (
    .clk(clk), .reset(reset), .ce(ce), .tape_in(tape_in), .motor_on(motor_on), .record(record),
    .byte_out(byte_out), .byte_addr(byte_addr), .byte_req(byte_req), .byte_ack(byte_ack),
    .running(running), .full(full), .overrun(overrun), .parity_errs(parity_errs),
    .last_addr(last_addr));

  oric_tap_recorder #(.SHORT_MAX(20), .LONG_MAX(40), .ADDR_W(4)) u_small (
    .clk(clk), .reset(reset), .ce(ce), .tape_in(tape_s), .motor_on(motor_on), .record(record),
    .byte_out(byte_out_s), .byte_addr(byte_addr_s), .byte_req(byte_req_s), .byte_ack(ack_s),
    .running(running_s), .full(full_s), .overrun(overrun_s), .parity_errs(parity_errs_s),
    .last_addr(last_addr_s));

  // ce is held high: one 1 MHz tick per clk keeps tape-length periods affordable.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete(); q_s.delete();
    m_addr = 0; s_addr = 0; m_perr = 0;
    outstanding = 1'b0; m_overrun = 1'b0; s_full = 1'b0;
  endtask

  // Frame-level model: a byte lands at the next free address unless a write is still outstanding.
  task automatic model_emit(input bit s, input logic [7:0] b, input bit bad);
    exp_t e;
    if (!(record && motor_on)) return;
    e.b = b;
    if (!s) begin
      if (bad && m_perr < 255) m_perr++;
      if (hold && outstanding) m_overrun = 1'b1;
      else begin
        e.a = 24'(m_addr); q_m.push_back(e); m_addr++; outstanding = hold;
      end
    end else if (!s_full) begin
      e.a = 24'(s_addr); q_s.push_back(e); s_addr++;
      if (s_addr == 15) s_full = 1'b1;
    end
  endtask

  // Rising edges p+1 clk apart; the tick coinciding with an edge is not counted, so period = p.
  task automatic send_period(input bit s, input int p);
    if (s) tape_s = 1'b0; else tape_in = 1'b0;
    repeat (p - 3) @(negedge clk);
    if (s) tape_s = 1'b1; else tape_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input bit s, input logic [7:0] b, input bit bad, input int p1, input int p0);
    bit pb;
    pb = (~^b) ^ bad;
    send_period(s, p0);
    for (int i = 0; i < 8; i++) send_period(s, b[i] ? p1 : p0);
    model_emit(s, b, bad);
    send_period(s, pb ? p1 : p0);
    repeat (3) send_period(s, p1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    settle(3);
    reset = 1'b0;
    model_reset();
    send_period(0, 50);
  endtask

  initial begin : ack_main
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (reset) begin byte_ack = 1'b0; n = 0; end
      else if (!hold && byte_req != byte_ack) begin
        n++;
        if (n == 4) begin byte_ack = byte_req; n = 0; end
      end else n = 0;
    end
  end

  initial begin : ack_small
    forever begin
      @(negedge clk);
      if (reset) ack_s = 1'b0;
      else if (byte_req_s != ack_s) begin settle(1); ack_s = byte_req_s; end
    end
  end

  initial begin : mon_main
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b0;
      else if (byte_req !== prev) begin
        prev = byte_req;
        chk("m_req_expected", q_m.size() > 0, 1);
        if (q_m.size() > 0) begin
          e = q_m.pop_front();
          chk("m_byte_out", byte_out, e.b);
          chk("m_byte_addr", byte_addr, e.a);
        end
      end
    end
  end

  initial begin : mon_small
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b0;
      else if (byte_req_s !== prev) begin
        prev = byte_req_s;
        chk("s_req_expected", q_s.size() > 0, 1);
        if (q_s.size() > 0) begin
          e = q_s.pop_front();
          chk("s_byte_out", byte_out_s, e.b);
          chk("s_byte_addr", byte_addr_s, e.a);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [7:0] b;
    settle(3);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_byte_addr", byte_addr, 0);
    chk("rst_byte_req", byte_req, 0);
    chk("rst_running", running, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_errs", parity_errs, 0);
    chk("rst_last_addr", last_addr, 0);
    reset = 1'b0;
    model_reset();
    send_period(0, 50);
    chk("running_on", running, 1);

    // Two well-formed frames at nominal tape timing.
    send_frame(0, 8'h16, 0, 416, 624);
    send_frame(0, 8'h24, 0, 416, 624);
    settle(10);
    chk("t1_last_addr", last_addr, 2);
    chk("t1_parity_errs", parity_errs, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_q_empty", q_m.size(), 0);

    // Wrong parity bit: byte still stored, error counted.
    do_reset();
    send_frame(0, 8'h24, 1, 40, 530);
    settle(10);
    chk("t2_parity_errs", parity_errs, 1);
    chk("t2_last_addr", last_addr, 1);
    chk("t2_q_empty", q_m.size(), 0);

    // Frame cut short by a silent gap, then a clean frame.
    do_reset();
    b = 8'($urandom);
    send_period(0, 530);
    for (int i = 0; i < 4; i++) send_period(0, b[i] ? 40 : 530);
    tape_in = 1'b0;
    settle(900);
    chk("t3_no_req", byte_req, 0);
    chk("t3_last_addr_gap", last_addr, 0);
    send_period(0, 50);
    send_frame(0, 8'($urandom), 0, 40, 530);
    settle(10);
    chk("t3_last_addr", last_addr, 1);
    chk("t3_q_empty", q_m.size(), 0);

    // Ack withheld: second byte dropped, first held; then release.
    do_reset();
    hold = 1'b1;
    b = 8'($urandom);
    send_frame(0, b, 0, 40, 530);
    send_frame(0, 8'($urandom), 0, 40, 530);
    settle(10);
    chk("t4_overrun", overrun, m_overrun);
    chk("t4_last_addr", last_addr, 1);
    chk("t4_held_byte", byte_out, b);
    chk("t4_held_addr", byte_addr, 0);
    chk("t4_req_pending", byte_req, 1);
    hold = 1'b0;
    settle(10);
    outstanding = 1'b0;
    send_frame(0, 8'($urandom), 0, 40, 530);
    settle(10);
    chk("t4_last_addr2", last_addr, 2);
    chk("t4_q_empty", q_m.size(), 0);

    // Classification boundaries, edge-less gap at 801, and motor/record gating.
    do_reset();
    send_frame(0, 8'($urandom), 0, 520, 521);
    send_frame(0, 8'($urandom), 0, 40, 800);
    send_period(0, 530);
    send_period(0, 40);
    send_period(0, 530);
    send_period(0, 801);
    send_frame(0, 8'($urandom), 0, 40, 530);
    settle(10);
    chk("t5_last_addr", last_addr, 3);
    chk("t5_q_empty", q_m.size(), 0);
    motor_on = 1'b0;
    settle(2);
    chk("t5_running_motor_off", running, 0);
    send_frame(0, 8'($urandom), 0, 40, 530);
    motor_on = 1'b1;
    settle(2);
    chk("t5_last_addr_motor_off", last_addr, 3);
    chk("t5_running_back", running, 1);
    record = 1'b0;
    settle(2);
    chk("t5_running_record_off", running, 0);
    record = 1'b1;
    settle(2);

    // Random byte, random parity, random periods inside each class.
    do_reset();
    send_frame(0, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(40, 520), $urandom_range(521, 700));
    settle(10);
    chk("t7_parity_errs", parity_errs, m_perr);
    chk("t7_last_addr", last_addr, m_addr);
    chk("t7_q_empty", q_m.size(), 0);

    // Asynchronous reset while in DATA with a request outstanding.
    do_reset();
    hold = 1'b1;
    send_frame(0, 8'($urandom_range(1, 255)), 0, 40, 530);
    send_period(0, 530);
    send_period(0, 40);
    send_period(0, 530);
    #3;
    chk("t6_pre_req", byte_req, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_req", byte_req, 0);
    chk("t6_async_byte_out", byte_out, 0);
    chk("t6_async_last_addr", last_addr, 0);
    chk("t6_async_running", running, 0);
    settle(3);
    reset = 1'b0;
    hold = 1'b0;
    model_reset();

    // Small address space fills after 15 bytes; the 16th is ignored.
    send_period(1, 10);
    for (int i = 0; i < 16; i++) begin
      send_frame(1, 8'($urandom), 0, 12, 30);
      settle(1);
      chk("s_full_progress", full_s, i >= 14);
    end
    settle(10);
    chk("s_last_addr", last_addr_s, 15);
    chk("s_running", running_s, 0);
    chk("s_q_empty", q_s.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
